// File: rtl/flux_burst_scheduler.sv
// flux_burst_scheduler
//   Round-robin, burst-locking scheduler that shares one tagged downstream
//   lane between FLUX upstream streams. Each burst is a length header
//   (low LEN_WIDTH bits = payload count L) followed by L payload tokens.
//   Once a flux wins arbitration its whole burst is forwarded without
//   interruption. Every token goes out as {tag, data}. The output is
//   registered: 1 token/cycle throughput and 1-cycle latency.
//
// Ports
//   clk, rst   : clock, asynchronous active-high reset
//   src_empty  : per-flux source FIFO empty
//   src_dout   : per-flux source data, flux i at [i*DATA_WIDTH +: DATA_WIDTH]
//   src_read   : per-flux read strobe (combinational, one-hot or zero)
//   dst_full   : downstream FIFO full
//   dst_write  : downstream write strobe
//   dst_din    : {tag, data} to downstream
//   busy       : locked mid-burst
//   cur_tag    : flux currently or last granted
module flux_burst_scheduler #(
  parameter int unsigned FLUX       = 2,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LEN_WIDTH  = 7,
  localparam int unsigned TAG_WIDTH = $clog2(FLUX)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [FLUX-1:0]                 src_empty,
  input  logic [FLUX*DATA_WIDTH-1:0]      src_dout,
  output logic [FLUX-1:0]                 src_read,
  input  logic                            dst_full,
  output logic                            dst_write,
  output logic [TAG_WIDTH+DATA_WIDTH-1:0] dst_din,
  output logic                            busy,
  output logic [TAG_WIDTH-1:0]            cur_tag
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [0:0]                      r_state;
  logic                            r_out_valid;
  logic [TAG_WIDTH+DATA_WIDTH-1:0] r_dout;
  logic [LEN_WIDTH-1:0]            r_remaining;
  logic [TAG_WIDTH-1:0]            r_rr_ptr;
  logic [TAG_WIDTH-1:0]            r_cur_tag;

  logic [DATA_WIDTH-1:0] w_src [FLUX];
  logic                  w_cand_valid;
  logic [TAG_WIDTH-1:0]  w_cand;
  logic [TAG_WIDTH-1:0]  w_idx;
  logic                  w_accept;
  logic [TAG_WIDTH-1:0]  w_sel;
  logic                  w_sel_ok;
  logic                  w_read;
  logic [DATA_WIDTH-1:0] w_data;
  logic [LEN_WIDTH-1:0]  w_len;

  always_comb begin
    for (int unsigned f = 0; f < FLUX; f++) begin
      w_src[f] = src_dout[f*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Round-robin search starting just after the last granted flux; the
  // modulo keeps the wrap correct for FLUX values that are not 2^n.
  always_comb begin
    w_cand_valid = 1'b0;
    w_cand       = '0;
    w_idx        = '0;
    for (int unsigned k = 1; k <= FLUX; k++) begin
      w_idx = TAG_WIDTH'((32'(r_rr_ptr) + k) % FLUX);
      if (!w_cand_valid && !src_empty[w_idx]) begin
        w_cand_valid = 1'b1;
        w_cand       = w_idx;
      end
    end
  end

  // Output slot can take a new token when empty or being drained this cycle.
  assign w_accept = !r_out_valid || !dst_full;

  // While locked only the owning flux is eligible.
  assign w_sel    = (r_state == S_BURST) ? r_cur_tag : w_cand;
  assign w_sel_ok = (r_state == S_BURST) ? !src_empty[r_cur_tag] : w_cand_valid;
  assign w_read   = w_sel_ok && w_accept;
  assign w_data   = w_src[w_sel];
  assign w_len    = w_data[LEN_WIDTH-1:0];

  assign src_read  = w_read ? ({{(FLUX-1){1'b0}}, 1'b1} << w_sel) : '0;
  assign dst_write = r_out_valid;
  assign dst_din   = r_dout;
  assign busy      = (r_state == S_BURST);
  assign cur_tag   = r_cur_tag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_dout      <= '0;
      r_remaining <= '0;
      r_rr_ptr    <= TAG_WIDTH'(FLUX - 1);
      r_cur_tag   <= '0;
    end else begin
      if (w_read) begin
        r_out_valid <= 1'b1;
        r_dout      <= {w_sel, w_data};
      end else if (!dst_full) begin
        r_out_valid <= 1'b0;
      end

      if (w_read) begin
        if (r_state == S_IDLE) begin
          r_cur_tag <= w_sel;
          if (w_len == '0) begin
            r_rr_ptr <= w_sel;
          end else begin
            r_remaining <= w_len;
            r_state     <= S_BURST;
          end
        end else begin
          r_remaining <= r_remaining - LEN_WIDTH'(1);
          if (r_remaining == LEN_WIDTH'(1)) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= r_cur_tag;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_flux_burst_scheduler.sv
// Testbench for flux_burst_scheduler (FLUX=4). The source FIFOs are queues
// held in the bench. A burst-level reference model predicts src_read and
// the output register every cycle. Directed scenarios pin the model with
// literal token sequences.
module tb_flux_burst_scheduler;
  localparam int FLUX = 4;
  localparam int DW   = 16;
  localparam int LW   = 7;
  localparam int TW   = 2;
  localparam int OW   = TW + DW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [FLUX-1:0] src_empty = '1;
  logic [FLUX*DW-1:0] src_dout = '0;
  logic [FLUX-1:0] src_read;
  logic            dst_full = 1'b0;
  logic            dst_write;
  logic [OW-1:0]   dst_din;
  logic            busy;
  logic [TW-1:0]   cur_tag;

  flux_burst_scheduler #(.FLUX(FLUX), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .src_empty(src_empty), .src_dout(src_dout),
    .src_read(src_read), .dst_full(dst_full), .dst_write(dst_write),
    .dst_din(dst_din), .busy(busy), .cur_tag(cur_tag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [DW-1:0] q    [FLUX][$];
  logic [DW-1:0] pend [FLUX][$];
  logic [FLUX-1:0] rd_snap = '0;
  logic [OW-1:0] out_log [$];
  int            out_cyc [$];

  // Reference model: lock owner (-1 = none), payload left, last grant,
  // and the output register contents.
  bit            m_valid;
  logic [OW-1:0] m_data;
  int            m_lock, m_rem, m_rr, m_tag;
  int            g, L;
  bit            acc;
  logic [FLUX-1:0] exp_rd;
  logic [DW-1:0] tok;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_lock = -1; m_rem = 0; m_rr = FLUX - 1; m_tag = 0;
  endtask

  task automatic drive_src();
    for (int i = 0; i < FLUX; i++) begin
      src_empty[i] = (q[i].size() == 0);
      src_dout[i*DW +: DW] = (q[i].size() != 0) ? q[i][0] : '0;
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < FLUX; i++) if (q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Compare and model step, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      model_reset();
      rd_snap = '0;
      chk("rst_dst_write", 32'(dst_write), 0);
      chk("rst_dst_din", 32'(dst_din), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_cur_tag", 32'(cur_tag), 0);
      chk("rst_src_read", 32'(src_read), 0);
    end else begin
      chk("dst_write", 32'(dst_write), 32'(m_valid));
      if (m_valid) chk("dst_din", 32'(dst_din), 32'(m_data));
      chk("busy", 32'(busy), 32'(m_lock >= 0));
      chk("cur_tag", 32'(cur_tag), 32'(m_tag));
      acc = !m_valid || !dst_full;
      g = -1;
      if (m_lock >= 0) begin
        if (q[m_lock].size() != 0) g = m_lock;
      end else begin
        for (int k = 1; k <= FLUX; k++)
          if (g < 0 && q[(m_rr + k) % FLUX].size() != 0) g = (m_rr + k) % FLUX;
      end
      if (!acc) g = -1;
      exp_rd = '0;
      if (g >= 0) exp_rd[g] = 1'b1;
      chk("src_read", 32'(src_read), 32'(exp_rd));
      rd_snap = src_read;
      if (dst_write && !dst_full) begin
        out_log.push_back(dst_din);
        out_cyc.push_back(cyc);
      end
      if (g >= 0) begin
        tok = q[g][0];
        m_valid = 1'b1;
        m_data = {TW'(g), tok};
        if (m_lock < 0) begin
          m_tag = g;
          L = int'(tok[LW-1:0]);
          if (L == 0) m_rr = g;
          else begin m_lock = g; m_rem = L; end
        end else begin
          m_rem--;
          if (m_rem == 0) begin m_lock = -1; m_rr = g; end
        end
      end else if (!dst_full) begin
        m_valid = 1'b0;
      end
    end
  end

  // Source FIFO pop after the edge at which the DUT read.
  always @(posedge clk) begin
    #1;
    if (!rst)
      for (int i = 0; i < FLUX; i++)
        if (rd_snap[i] && q[i].size() != 0) void'(q[i].pop_front());
    rd_snap = '0;
    drive_src();
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int f, input logic [DW-1:0] v);
    q[f].push_back(v);
    drive_src();
  endtask

  task automatic clear_log();
    out_log.delete();
    out_cyc.delete();
  endtask

  task automatic wait_idle(input int maxc, input string name);
    int n = 0;
    while ((!all_empty() || dst_write || busy) && n < maxc) begin
      step();
      n++;
    end
    checks++;
    if (n >= maxc) begin
      errors++;
      $display("FAIL %s_idle: still active after %0d cycles, required idle", name, maxc);
    end
  endtask

  task automatic exp_log(input string name, input int idx, input logic [OW-1:0] exp);
    checks++;
    if (idx >= out_log.size()) begin
      errors++;
      $display("FAIL %s: token %0d missing, required %0h", name, idx, exp);
    end else if (out_log[idx] !== exp) begin
      errors++;
      $display("FAIL %s: token %0d got %0h required %0h", name, idx, out_log[idx], exp);
    end
  endtask

  task automatic gen_burst(input int f);
    logic [DW-1:0] h;
    int n;
    n = ($urandom_range(0, 99) == 0) ? (2**LW - 1) : int'($urandom_range(0, 6));
    h = DW'($urandom);
    h[LW-1:0] = LW'(n);
    pend[f].push_back(h);
    for (int i = 0; i < n; i++) pend[f].push_back(DW'($urandom));
  endtask

  initial begin
    model_reset();
    drive_src();
    repeat (3) step();
    rst = 1'b0;

    // 1: two short bursts back to back
    clear_log();
    push(0, 16'h0002); push(0, 16'hAAAA); push(0, 16'hBBBB);
    push(1, 16'h0001); push(1, 16'hCCCC);
    wait_idle(50, "t1");
    exp_log("t1_tok", 0, {2'd0, 16'h0002});
    exp_log("t1_tok", 1, {2'd0, 16'hAAAA});
    exp_log("t1_tok", 2, {2'd0, 16'hBBBB});
    exp_log("t1_tok", 3, {2'd1, 16'h0001});
    exp_log("t1_tok", 4, {2'd1, 16'hCCCC});
    chk("t1_count", 32'(out_log.size()), 5);
    if (out_cyc.size() == 5) chk("t1_consecutive", 32'(out_cyc[4] - out_cyc[0]), 4);

    // 2: fairness with zero-length headers
    clear_log();
    for (int j = 0; j < 6; j++) begin
      push(0, DW'(j << 8));
      push(1, DW'(16'h8000 | (j << 8)));
    end
    wait_idle(60, "t2");
    chk("t2_count", 32'(out_log.size()), 12);
    for (int k = 0; k < 12; k++)
      exp_log("t2_alt", k, {TW'(k % 2), DW'(((k % 2) ? 16'h8000 : 16'h0000) | ((k / 2) << 8))});

    // 3: backpressure during payload
    clear_log();
    push(0, 16'h0003); push(0, 16'h3001); push(0, 16'h3002); push(0, 16'h3003);
    step(); step();
    dst_full = 1'b1;
    repeat (3) step();
    dst_full = 1'b0;
    wait_idle(50, "t3");
    chk("t3_count", 32'(out_log.size()), 4);
    exp_log("t3_tok", 0, {2'd0, 16'h0003});
    exp_log("t3_tok", 1, {2'd0, 16'h3001});
    exp_log("t3_tok", 2, {2'd0, 16'h3002});
    exp_log("t3_tok", 3, {2'd0, 16'h3003});

    // 4: lock held while owner is empty
    clear_log();
    push(0, 16'h0003); push(0, 16'h4001);
    repeat (3) step();
    push(1, 16'h0001); push(1, 16'h4444);
    repeat (4) step();
    chk("t4_locked_busy", 32'(busy), 1);
    chk("t4_no_read", 32'(src_read), 0);
    push(0, 16'h4002); push(0, 16'h4003);
    wait_idle(50, "t4");
    exp_log("t4_tok", 0, {2'd0, 16'h0003});
    exp_log("t4_tok", 1, {2'd0, 16'h4001});
    exp_log("t4_tok", 2, {2'd0, 16'h4002});
    exp_log("t4_tok", 3, {2'd0, 16'h4003});
    exp_log("t4_tok", 4, {2'd1, 16'h0001});
    exp_log("t4_tok", 5, {2'd1, 16'h4444});
    if (out_cyc.size() == 6) chk("t4_next_cycle", 32'(out_cyc[4] - out_cyc[3]), 1);

    // 5: pointer wrap after a flux3 burst
    clear_log();
    push(3, 16'h0001); push(3, 16'h5003);
    wait_idle(30, "t5a");
    push(0, 16'h0001); push(0, 16'h5000);
    push(2, 16'h0001); push(2, 16'h5002);
    wait_idle(30, "t5b");
    exp_log("t5_tok", 0, {2'd3, 16'h0001});
    exp_log("t5_tok", 1, {2'd3, 16'h5003});
    exp_log("t5_tok", 2, {2'd0, 16'h0001});
    exp_log("t5_tok", 3, {2'd0, 16'h5000});
    exp_log("t5_tok", 4, {2'd2, 16'h0001});
    exp_log("t5_tok", 5, {2'd2, 16'h5002});

    // 6: async reset with flux1 locked, remaining=2, output held
    push(1, 16'h0004); push(1, 16'h6001); push(1, 16'h6002);
    repeat (3) step();
    dst_full = 1'b1;
    step();
    chk("t6_pre_busy", 32'(busy), 1);
    chk("t6_pre_write", 32'(dst_write), 1);
    #1;
    rst = 1'b1;
    dst_full = 1'b0;
    for (int f = 0; f < FLUX; f++) q[f].delete();
    drive_src();
    #1;
    chk("t6_rst_write", 32'(dst_write), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    step(); step();
    rst = 1'b0;
    clear_log();
    push(0, 16'h0001); push(0, 16'h6100);
    push(1, 16'h0001); push(1, 16'h6101);
    wait_idle(30, "t6");
    exp_log("t6_tok", 0, {2'd0, 16'h0001});
    exp_log("t6_tok", 1, {2'd0, 16'h6100});
    exp_log("t6_tok", 2, {2'd1, 16'h0001});

    // Random traffic with random backpressure
    for (int c = 0; c < 3000; c++) begin
      step();
      dst_full = ($urandom_range(0, 3) == 0);
      for (int f = 0; f < FLUX; f++) begin
        if (pend[f].size() == 0) gen_burst(f);
        if ($urandom_range(0, 5) == 0) push(f, pend[f].pop_front());
      end
    end
    dst_full = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      step();
      for (int f = 0; f < FLUX; f++)
        if (pend[f].size() != 0) push(f, pend[f].pop_front());
    end
    wait_idle(4000, "rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
